// File: rtl/rv32i_types.sv
// Shared RV32I type definitions.
// Holds the machine word and register index types, plus the state encoding
// used by mem_port_arbiter.
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [4:0]  rv32i_reg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// arb_priority_pick: combinational one-hot winner selection.
// Scans the request vector starting at index ptr and wrapping modulo
// NUM_PORTS. With ptr tied to 0 it reduces to fixed lowest-index priority.
// Ports:
//   req   in  NUM_PORTS  request vector
//   ptr   in  PTR_W      scan start index
//   grant out NUM_PORTS  one-hot winner (all zero when no request)
module arb_priority_pick #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned PTR_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] grant
);

  logic found;

  // Outer loop walks the scan order (ptr, ptr+1, ...); inner loop maps that
  // position back to a port index so every select uses a loop constant.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      for (int unsigned j = 0; j < NUM_PORTS; j++) begin
        if (!found && req[j] && (((32'(ptr) + i) % NUM_PORTS) == j)) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream memory port among NUM_PORTS
// requesters (port 0 = instruction fetch, port 1 = data).
// One transaction at a time: IDLE picks a winner and latches its request,
// BUSY drives the latched request downstream until mem_resp, RESP pulses
// port_resp[winner] for one cycle with the registered read data.
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   port_read/port_write   [N]         per-port requests (both high = write)
//   port_wmask/address/wdata [N][..]   per-port request fields
//   port_resp [N], port_rdata          one-hot completion pulse and read data
//   mem_read/mem_write/wmask/address/wdata  downstream request
//   mem_resp, mem_rdata                downstream completion and read data
// Configuration: define MEM_ARB_RR_EN for round-robin arbitration; without
// it the lowest-index requester wins and no pointer exists.
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_PORTS-1:0]                 port_read,
  input  logic [NUM_PORTS-1:0]                 port_write,
  input  logic [NUM_PORTS-1:0][DATA_W/8-1:0]   port_wmask,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]     port_address,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]     port_wdata,
  output logic [NUM_PORTS-1:0]                 port_resp,
  output logic [DATA_W-1:0]                    port_rdata,
  output logic                                 mem_read,
  output logic                                 mem_write,
  output logic [DATA_W/8-1:0]                  mem_wmask,
  output logic [ADDR_W-1:0]                    mem_address,
  output logic [DATA_W-1:0]                    mem_wdata,
  input  logic                                 mem_resp,
  input  logic [DATA_W-1:0]                    mem_rdata
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_t             state_q, state_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic                   write_q, write_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [MASK_W-1:0]      wmask_q, wmask_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;

  logic [NUM_PORTS-1:0]   req;
  logic [NUM_PORTS-1:0]   pick_grant;
  logic [PTR_W-1:0]       pick_ptr;

`ifdef MEM_ARB_RR_EN
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  assign pick_ptr = ptr_q;
`else
  assign pick_ptr = '0;
`endif

  assign req = port_read | port_write;

  arb_priority_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .grant (pick_grant)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
`ifdef MEM_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BUSY;
          grant_d = pick_grant;
          for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            if (pick_grant[j]) begin
              write_d = port_write[j];
              addr_d  = port_address[j];
              wdata_d = port_wdata[j];
              wmask_d = port_wmask[j];
`ifdef MEM_ARB_RR_EN
              ptr_d   = PTR_W'((j + 1) % NUM_PORTS);
`endif
            end
          end
        end
      end
      BUSY: begin
        if (mem_resp) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
`ifdef MEM_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Strobes decode straight from the state register so an async reset
  // drops them immediately.
  assign mem_read    = (state_q == BUSY) && !write_q;
  assign mem_write   = (state_q == BUSY) &&  write_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wmask   = wmask_q;
  assign port_resp   = (state_q == RESP) ? grant_q : '0;
  assign port_rdata  = (state_q == RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // two-port instance
  logic [1:0]        p_read, p_write, p_resp;
  logic [1:0][3:0]   p_wmask;
  logic [1:0][31:0]  p_addr, p_wdata;
  logic [31:0]       p_rdata, m_addr, m_wdata, m_rdata;
  logic              m_read, m_write, m_resp;
  logic [3:0]        m_wmask;

  // four-port instance
  logic [3:0]        p_read4, p_write4, p_resp4;
  logic [3:0][3:0]   p_wmask4;
  logic [3:0][31:0]  p_addr4, p_wdata4;
  logic [31:0]       p_rdata4, m_addr4, m_wdata4, m_rdata4;
  logic              m_read4, m_write4, m_resp4;
  logic [3:0]        m_wmask4;

  mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .port_read(p_read), .port_write(p_write), .port_wmask(p_wmask),
    .port_address(p_addr), .port_wdata(p_wdata),
    .port_resp(p_resp), .port_rdata(p_rdata),
    .mem_read(m_read), .mem_write(m_write), .mem_wmask(m_wmask),
    .mem_address(m_addr), .mem_wdata(m_wdata),
    .mem_resp(m_resp), .mem_rdata(m_rdata)
  );

  mem_port_arbiter #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32)) u_dut4 (
    .clk(clk), .reset_n(reset_n),
    .port_read(p_read4), .port_write(p_write4), .port_wmask(p_wmask4),
    .port_address(p_addr4), .port_wdata(p_wdata4),
    .port_resp(p_resp4), .port_rdata(p_rdata4),
    .mem_read(m_read4), .mem_write(m_write4), .mem_wmask(m_wmask4),
    .mem_address(m_addr4), .mem_wdata(m_wdata4),
    .mem_resp(m_resp4), .mem_rdata(m_rdata4)
  );

  typedef struct {
    int          port;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    p_read   = '0; p_write  = '0; m_resp  = 1'b0; m_rdata  = '0;
    p_read4  = '0; p_write4 = '0; m_resp4 = 1'b0; m_rdata4 = '0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    idle_all();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_all();
    p_addr = '0; p_wdata = '0; p_wmask = '0;
    for (int i = 0; i < 4; i++) begin
      p_addr4[i]  = 32'(i * 256);
      p_wdata4[i] = '0;
      p_wmask4[i] = '0;
    end
    #3;
    n_cmp++;
    if ({p_resp, m_read, m_write, m_wmask, m_addr, m_wdata, p_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_outs_2p got resp=%b rd=%b wr=%b m=%b a=%h d=%h r=%h want all zero",
               p_resp, m_read, m_write, m_wmask, m_addr, m_wdata, p_rdata);
    end
    n_cmp++;
    if ({p_resp4, m_read4, m_write4, m_wmask4, m_addr4, m_wdata4, p_rdata4} !== '0) begin
      n_err++;
      $display("FAIL reset_outs_4p got resp=%b rd=%b wr=%b a=%h want all zero",
               p_resp4, m_read4, m_write4, m_addr4);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  // One full transaction on the two-port instance with mem_resp in BUSY cycle 'delay'.
  task automatic do_txn(input int port, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wmask, input logic [31:0] rdata,
                        input int delay);
    exp_t e;
    p_read[port]  = rd;
    p_write[port] = wr;
    p_addr[port]  = addr;
    p_wdata[port] = wdata;
    p_wmask[port] = wmask;
    e.port = port; e.chk = !wr; e.data = rdata;
    sb.push_back(e);
    tick();
    for (int k = 0; k < delay; k++) begin
      n_cmp++;
      if ({m_read, m_write, m_addr, m_wdata, m_wmask} !== {!wr, wr, addr, wdata, wmask}) begin
        n_err++;
        $display("FAIL busy_fields cyc=%0d got rd=%b wr=%b a=%h d=%h m=%b want rd=%b wr=%b a=%h d=%h m=%b",
                 k, m_read, m_write, m_addr, m_wdata, m_wmask, !wr, wr, addr, wdata, wmask);
      end
      n_cmp++;
      if (p_resp !== 2'b00) begin
        n_err++;
        $display("FAIL early_resp cyc=%0d got %b want 00", k, p_resp);
      end
      if (k == delay - 1) begin
        m_resp  = 1'b1;
        m_rdata = rdata;
      end
      tick();
    end
    m_resp = 1'b0;
    n_cmp++;
    if ({m_read, m_write} !== 2'b00) begin
      n_err++;
      $display("FAIL mem_drop got rd=%b wr=%b want 0 0", m_read, m_write);
    end
    n_cmp++;
    e = sb.pop_front();
    if (p_resp !== 2'(1 << e.port) || (e.chk && p_rdata !== e.data)) begin
      n_err++;
      $display("FAIL resp got resp=%b rdata=%h want resp=%b rdata=%h",
               p_resp, p_rdata, 2'(1 << e.port), e.data);
    end
    p_read[port]  = 1'b0;
    p_write[port] = 1'b0;
    tick();
    n_cmp++;
    if (p_resp !== 2'b00) begin
      n_err++;
      $display("FAIL resp_width got %b want 00", p_resp);
    end
  endtask

  task automatic test_single_read();
    do_txn(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'hDEAD_BEEF, 1);
  endtask

  task automatic test_write();
    do_txn(1, 1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'b0011, 32'h0, 5);
  endtask

  task automatic test_read_write_conflict();
    do_txn(0, 1'b1, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 4'hF, 32'h0, 2);
  endtask

  task automatic test_stray_resp();
    m_resp  = 1'b1;
    m_rdata = 32'h5555_AAAA;
    tick();
    n_cmp++;
    if ({p_resp, m_read, m_write} !== 4'b0000) begin
      n_err++;
      $display("FAIL stray_resp got resp=%b rd=%b wr=%b want 00 0 0", p_resp, m_read, m_write);
    end
    m_resp = 1'b0;
    tick();
    n_cmp++;
    if (p_resp !== 2'b00) begin
      n_err++;
      $display("FAIL stray_resp_late got %b want 00", p_resp);
    end
    do_txn(1, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'h0, 32'h0BAD_F00D, 1);
  endtask

  task automatic test_contention();
    exp_t e;
    int   g;
    apply_reset();
    p_addr[0] = 32'h100;
    p_addr[1] = 32'h200;
    p_read    = 2'b11;
    for (int n = 0; n < 4; n++) begin
      g = RR_EN ? (n % 2) : 0;
      e.port = g; e.chk = 1'b1; e.data = 32'(n + 32'h77);
      sb.push_back(e);
      tick();
      n_cmp++;
      if (m_read !== 1'b1 || m_addr !== 32'((g + 1) * 256)) begin
        n_err++;
        $display("FAIL contention_grant n=%0d got rd=%b a=%h want rd=1 a=%h",
                 n, m_read, m_addr, 32'((g + 1) * 256));
      end
      m_resp  = 1'b1;
      m_rdata = 32'(n + 32'h77);
      tick();
      m_resp = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if (p_resp !== 2'(1 << e.port) || p_rdata !== e.data) begin
        n_err++;
        $display("FAIL contention_resp n=%0d got resp=%b r=%h want resp=%b r=%h",
                 n, p_resp, p_rdata, 2'(1 << e.port), e.data);
      end
      tick();
    end
    p_read = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    exp_t e;
    apply_reset();
    p_addr[0] = 32'h300;
    p_addr[1] = 32'h400;
    p_read[0] = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
    p_read  = 2'b00;
    #1;
    n_cmp++;
    if ({m_read, m_write} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_async_drop got rd=%b wr=%b want 0 0", m_read, m_write);
    end
    m_resp = 1'b1;
    tick();
    n_cmp++;
    if (p_resp !== 2'b00) begin
      n_err++;
      $display("FAIL reset_no_resp got %b want 00", p_resp);
    end
    m_resp = 1'b0;
    tick();
    reset_n = 1'b1;
    // pointer back at 0: both requesting must pick port 0 in either policy
    p_read = 2'b11;
    e.port = 0; e.chk = 1'b1; e.data = 32'h1357_9BDF;
    sb.push_back(e);
    tick();
    n_cmp++;
    if (m_read !== 1'b1 || m_addr !== 32'h300) begin
      n_err++;
      $display("FAIL reset_ptr got rd=%b a=%h want rd=1 a=00000300", m_read, m_addr);
    end
    m_resp  = 1'b1;
    m_rdata = 32'h1357_9BDF;
    tick();
    m_resp = 1'b0;
    p_read = 2'b00;
    e = sb.pop_front();
    n_cmp++;
    if (p_resp !== 2'(1 << e.port) || p_rdata !== e.data) begin
      n_err++;
      $display("FAIL reset_after_resp got resp=%b r=%h want resp=%b r=%h",
               p_resp, p_rdata, 2'(1 << e.port), e.data);
    end
    tick();
  endtask

  task automatic arb4(input logic [3:0] req, input int exp_port);
    exp_t e;
    p_read4 = req;
    e.port = exp_port; e.chk = 1'b1; e.data = 32'(32'hA0 + exp_port);
    sb.push_back(e);
    tick();
    n_cmp++;
    if (m_read4 !== 1'b1 || m_addr4 !== 32'(exp_port * 256)) begin
      n_err++;
      $display("FAIL wrap_grant req=%b got rd=%b a=%h want rd=1 a=%h",
               req, m_read4, m_addr4, 32'(exp_port * 256));
    end
    m_resp4  = 1'b1;
    m_rdata4 = 32'(32'hA0 + exp_port);
    tick();
    m_resp4 = 1'b0;
    p_read4 = '0;
    e = sb.pop_front();
    n_cmp++;
    if (p_resp4 !== 4'(1 << e.port) || p_rdata4 !== e.data) begin
      n_err++;
      $display("FAIL wrap_resp req=%b got resp=%b r=%h want resp=%b r=%h",
               req, p_resp4, p_rdata4, 4'(1 << e.port), e.data);
    end
    tick();
  endtask

  task automatic test_wrap4();
    apply_reset();
    arb4(4'b0100, 2);
    arb4(4'b0101, 0);
    arb4(4'b0011, RR_EN ? 1 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_read_write_conflict();
    test_stray_resp();
    test_contention();
    test_reset_mid_busy();
    test_wrap4();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_left got %0d entries want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
